// File: rtl/sha_core_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sha_core_arbiter
//  Purpose  : Shares one SHA-256 hashing core among NUM_REQ nonce-search
//             controllers. A round-robin arbiter picks a requester and drives
//             the core data-mux select. It issues a one-cycle begin pulse to
//             the core, waits for the core's complete flag, and returns a
//             one-cycle done pulse to the winner.
//  Optional : SHA_ARB_TIMEOUT_EN adds a WAIT-state watchdog. On expiry the
//             core is aborted and the winner gets a timeout_err pulse. When the
//             macro is undefined, o_core_abort and o_timeout_err are tied to 0.
//  Ports    :
//     clk              in   1        clock, rising edge
//     n_rst            in   1        asynchronous active-low reset
//     i_req            in   NUM_REQ  level requests, held until done/timeout
//     i_core_complete  in   1        core result valid (level or pulse)
//     o_gnt            out  NUM_REQ  one-hot grant, held for the transaction
//     o_core_sel       out  IDX_W    index of granted requester (mux select)
//     o_core_begin     out  1        one-cycle start pulse to the core
//     o_done           out  NUM_REQ  one-cycle done pulse to the winner
//     o_busy           out  1        high in every state except IDLE
//     o_core_abort     out  1        one-cycle core abort (watchdog build)
//     o_timeout_err    out  NUM_REQ  one-cycle timeout pulse (watchdog build)
//  Revision : 1.0  initial release
// ============================================================================
module sha_core_arbiter #(
   parameter  int NUM_REQ        = 4,
   parameter  int TIMEOUT_CYCLES = 128,
   localparam int IDX_W          = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic [NUM_REQ-1:0] i_req,
   input  logic               i_core_complete,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_core_sel,
   output logic               o_core_begin,
   output logic [NUM_REQ-1:0] o_done,
   output logic               o_busy,
   output logic               o_core_abort,
   output logic [NUM_REQ-1:0] o_timeout_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_GRANT = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ABORT = 3'd5;

   logic [2:0]         r_state;
   logic [IDX_W-1:0]   r_ptr;      // last serviced requester (lowest priority)
   logic [IDX_W-1:0]   r_sel;      // current / most recent winner
   logic [IDX_W-1:0]   w_winner;
   logic               w_any_req;
   logic [NUM_REQ-1:0] w_sel_oh;
   logic               w_wd_expired;

   // ------------------------------------------------------------------------
   // Round-robin winner: search ptr+1, ptr+2, ... modulo NUM_REQ. Scanning
   // from the far end lets the closest set bit overwrite the result, so no
   // early exit is needed. Modulo NUM_REQ keeps non-power-of-two counts from
   // ever producing an out-of-range index.
   // ------------------------------------------------------------------------
   always_comb begin
      w_winner = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_winner = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign w_any_req = |i_req;

   always_comb begin
      w_sel_oh = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_sel_oh[i] = (r_sel == IDX_W'(i));
      end
   end

   // ------------------------------------------------------------------------
   // Optional WAIT watchdog. The counter is cleared in START so that it reads
   // zero on the first WAIT cycle; the n-th WAIT cycle therefore sees n-1.
   // ------------------------------------------------------------------------
`ifdef SHA_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] r_wd_cnt;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wd_cnt <= '0;
      end else if (r_state == S_START) begin
         r_wd_cnt <= '0;
      end else if (r_state == S_WAIT) begin
         r_wd_cnt <= r_wd_cnt + CNT_W'(1);
      end
   end

   assign w_wd_expired = (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign w_wd_expired = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Transaction FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= S_IDLE;
         r_ptr   <= IDX_W'(NUM_REQ - 1);
         r_sel   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_sel   <= w_winner;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               // Requester withdrew during the mux settle cycle: back off
               // without touching the core or the rotation pointer.
               r_state <= i_req[r_sel] ? S_START : S_IDLE;
            end
            S_START: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // A completion on the last watchdog cycle takes priority.
               if (i_core_complete) begin
                  r_state <= S_DONE;
               end else if (w_wd_expired) begin
                  r_state <= S_ABORT;
               end
            end
            S_DONE, S_ABORT: begin
               r_ptr   <= r_sel;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: decoded only from state and the registered select.
   // ------------------------------------------------------------------------
   assign o_busy       = (r_state != S_IDLE);
   assign o_gnt        = o_busy ? w_sel_oh : '0;
   assign o_core_sel   = r_sel;
   assign o_core_begin = (r_state == S_START);
   assign o_done       = (r_state == S_DONE) ? w_sel_oh : '0;

`ifdef SHA_ARB_TIMEOUT_EN
   assign o_core_abort  = (r_state == S_ABORT);
   assign o_timeout_err = (r_state == S_ABORT) ? w_sel_oh : '0;
`else
   assign o_core_abort  = 1'b0;
   assign o_timeout_err = '0;
`endif

endmodule
`default_nettype wire
